poly_note_gen: RTL

//  Parametrised multi-channel successor to the single square-wave note generator.

---
 rtl/poly_note_gen.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/poly_note_gen.sv
// poly_note_gen: multi-channel tone generator with a saturating stereo mixer.
//
// Each of the NCH channels has these parts:
//   - a half-period divider
//   - an amplitude
//   - a waveform mode (off / square / 25% pulse / square with decay)
//   - a decay envelope
//   - a left/right pan mask
// The channel levels are summed per side. Each sum is clamped to the signed
// AMP_W range and registered into audio_left / audio_right.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   note_we      write strobe; programs channel note_ch at the next edge
//   note_ch      target channel; values >= NCH are ignored
//   note_div     half-period minus 1 in clocks; 0 silences the channel
//   note_amp     peak magnitude (unsigned, AMP_W-1 bits)
//   note_mode    00 off, 01 square, 10 25% pulse, 11 square+decay
//   note_pan     bit0 enables left, bit1 enables right
//   ch_active    registered per-channel "level can be non-zero" flag
//   audio_left   signed mixed left sample
//   audio_right  signed mixed right sample
module poly_note_gen #(
    parameter int NCH       = 4,
    parameter int DIV_W     = 22,
    parameter int AMP_W     = 16,
    parameter int DECAY_DIV = 4096
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   note_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] note_ch,
    input  logic [DIV_W-1:0]                       note_div,
    input  logic [AMP_W-2:0]                       note_amp,
    input  logic [1:0]                             note_mode,
    input  logic [1:0]                             note_pan,
    output logic [NCH-1:0]                         ch_active,
    output logic [AMP_W-1:0]                       audio_left,
    output logic [AMP_W-1:0]                       audio_right
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int SUM_W = AMP_W + $clog2(NCH) + 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_DIV - 1);

    // Clamp limits: SAT_HI is 0..01..1 (2^(AMP_W-1)-1).
    // Its complement is 1..10..0 (-2^(AMP_W-1)).
    localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-AMP_W+1){1'b0}}, {(AMP_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b10;
    localparam logic [1:0] MODE_DECAY = 2'b11;

    logic [DIV_W-1:0] div_q   [NCH];
    logic [DIV_W-1:0] cnt_q   [NCH];
    logic [AMP_W-2:0] amp_q   [NCH];
    logic [AMP_W-2:0] env_q   [NCH];
    logic [1:0]       mode_q  [NCH];
    logic [1:0]       pan_q   [NCH];
    logic [PRE_W-1:0] pre_q   [NCH];
    logic             phase_q [NCH];

    logic [NCH-1:0]          wr_sel;
    logic [AMP_W-2:0]        mag   [NCH];
    logic signed [SUM_W-1:0] lvl   [NCH];
    logic [NCH-1:0]          act_nxt;
    logic signed [SUM_W-1:0] sum_l;
    logic signed [SUM_W-1:0] sum_r;

    // An out-of-range note_ch never equals any channel index.
    // Writes to it therefore select nothing.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = note_we && (note_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i]   <= '0;
                cnt_q[i]   <= '0;
                amp_q[i]   <= '0;
                env_q[i]   <= '0;
                mode_q[i]  <= MODE_OFF;
                pan_q[i]   <= '0;
                pre_q[i]   <= '0;
                phase_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_sel[i]) begin
                    // A write restarts the channel.
                    // It takes priority over a terminal count in the same cycle.
                    div_q[i]   <= note_div;
                    amp_q[i]   <= note_amp;
                    env_q[i]   <= note_amp;
                    mode_q[i]  <= note_mode;
                    pan_q[i]   <= note_pan;
                    cnt_q[i]   <= '0;
                    phase_q[i] <= 1'b0;
                    pre_q[i]   <= '0;
                end else begin
                    if (cnt_q[i] == div_q[i]) begin
                        cnt_q[i]   <= '0;
                        phase_q[i] <= ~phase_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                    if (mode_q[i] == MODE_DECAY) begin
                        if (pre_q[i] == PRE_LAST) begin
                            pre_q[i] <= '0;
                            if (env_q[i] != '0) begin
                                env_q[i] <= env_q[i] - 1'b1;
                            end
                        end else begin
                            pre_q[i] <= pre_q[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mag[i] = (mode_q[i] == MODE_DECAY) ? env_q[i] : amp_q[i];
            lvl[i] = '0;
            if (mode_q[i] != MODE_OFF && div_q[i] != '0 && mag[i] != '0) begin
                if (mode_q[i] == MODE_PULSE) begin
                    // High only for the first half of the phase-0 half-period.
                    // That gives a 25% duty cycle.
                    if (!phase_q[i] && cnt_q[i] <= (div_q[i] >> 1)) begin
                        lvl[i] = $signed(SUM_W'(mag[i]));
                    end else begin
                        lvl[i] = -$signed(SUM_W'(mag[i]));
                    end
                end else begin
                    lvl[i] = phase_q[i] ? -$signed(SUM_W'(mag[i])) : $signed(SUM_W'(mag[i]));
                end
            end
            act_nxt[i] = (lvl[i] != '0);
        end
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pan_q[i][0]) sum_l = sum_l + lvl[i];
            if (pan_q[i][1]) sum_r = sum_r + lvl[i];
        end
    end

    function automatic logic [AMP_W-1:0] sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] c;
        if (s > SAT_HI) begin
            c = SAT_HI;
        end else if (s < SAT_LO) begin
            c = SAT_LO;
        end else begin
            c = s;
        end
        return c[AMP_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_left  <= '0;
            audio_right <= '0;
            ch_active   <= '0;
        end else begin
            audio_left  <= sat(sum_l);
            audio_right <= sat(sum_r);
            ch_active   <= act_nxt;
        end
    end

endmodule
